// File: rtl/rc4_key_search_ctrl_if.sv
// Control, status and per-core handshake bundle of the RC4 key-search controller.
// The controller uses the master view; the host/core side uses the slave view.
interface rc4_key_search_ctrl_if #(
    parameter int unsigned KEY_WIDTH   = 24,
    parameter int unsigned SEARCH_BITS = 22,
    parameter int unsigned NUM_CORES   = 4
);
    logic                           start;
    logic                           abort;
    logic [SEARCH_BITS-1:0]         key_lo;
    logic [SEARCH_BITS-1:0]         key_hi;
    logic [NUM_CORES-1:0]           core_start;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
    logic [NUM_CORES-1:0]           core_done;
    logic [NUM_CORES-1:0]           core_success;
    logic                           busy;
    logic                           found;
    logic                           exhausted;
    logic [KEY_WIDTH-1:0]           found_key;
    logic [SEARCH_BITS:0]           keys_tried;

    modport master (
        input  start, abort, key_lo, key_hi, core_done, core_success,
        output core_start, core_key, busy, found, exhausted, found_key, keys_tried
    );

    modport slave (
        output start, abort, key_lo, key_hi, core_done, core_success,
        input  core_start, core_key, busy, found, exhausted, found_key, keys_tried
    );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// Sweeps a key range across NUM_CORES RC4 crack cores in lockstep rounds and stops on the
// first successful key (lowest core index wins within a round) or when the range runs out.
module rc4_key_search_ctrl #(
    parameter int unsigned KEY_WIDTH   = 24,
    parameter int unsigned SEARCH_BITS = 22,
    parameter int unsigned NUM_CORES   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    rc4_key_search_ctrl_if.master bus
);
    typedef logic [SEARCH_BITS:0] ext_t;

    typedef enum logic [2:0] {
        StIdle, StDispatch, StWait, StEval, StFound, StExhausted
    } state_e;

    state_e                         state_q, state_d;
    logic [SEARCH_BITS-1:0]         next_key_q, next_key_d;
    logic [SEARCH_BITS-1:0]         key_hi_q, key_hi_d;
    logic [NUM_CORES-1:0]           active_q, active_d;
    logic [NUM_CORES-1:0]           done_q, done_d;
    logic [NUM_CORES-1:0]           succ_q, succ_d;
    logic [NUM_CORES-1:0]           core_start_q, core_start_d;
    logic [NUM_CORES*KEY_WIDTH-1:0] core_key_q, core_key_d;
    logic                           busy_q, busy_d;
    logic                           found_q, found_d;
    logic                           exhausted_q, exhausted_d;
    logic [KEY_WIDTH-1:0]           found_key_q, found_key_d;
    ext_t                           keys_tried_q, keys_tried_d;

    logic [NUM_CORES-1:0]           accepted;
    ext_t                           tried_inc;
    ext_t                           next_step;
    logic [KEY_WIDTH-1:0]           win_key;
    logic                           load_round;
    ext_t                           cand;

    // Datapath terms that depend only on registered state and core inputs.
    always_comb begin
        accepted  = bus.core_done & active_q & ~done_q;
        tried_inc = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            tried_inc = tried_inc + ext_t'(accepted[i]);
        end
        // Scan downwards so the lowest succeeding index is the last one written.
        win_key = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (succ_q[i]) begin
                win_key = core_key_q[i*KEY_WIDTH +: KEY_WIDTH];
            end
        end
        next_step = ext_t'(next_key_q) + ext_t'(NUM_CORES);
    end

    always_comb begin
        state_d      = state_q;
        next_key_d   = next_key_q;
        key_hi_d     = key_hi_q;
        active_d     = active_q;
        done_d       = done_q;
        succ_d       = succ_q;
        core_start_d = '0;
        core_key_d   = core_key_q;
        found_d      = found_q;
        exhausted_d  = exhausted_q;
        found_key_d  = found_key_q;
        keys_tried_d = keys_tried_q;
        load_round   = 1'b0;
        cand         = '0;

        case (state_q)
            StIdle, StFound, StExhausted: begin
                if (bus.start) begin
                    key_hi_d     = bus.key_hi;
                    found_d      = 1'b0;
                    exhausted_d  = 1'b0;
                    keys_tried_d = '0;
                    if (bus.key_lo > bus.key_hi) begin
                        exhausted_d = 1'b1;
                        state_d     = StExhausted;
                    end else begin
                        next_key_d = bus.key_lo;
                        load_round = 1'b1;
                        state_d    = StDispatch;
                    end
                end
            end
            StDispatch: begin
                done_d  = '0;
                succ_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                done_d       = done_q | accepted;
                succ_d       = succ_q | (accepted & bus.core_success);
                keys_tried_d = keys_tried_q + tried_inc;
                if (done_d == active_q) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                if (|succ_q) begin
                    found_key_d = win_key;
                    found_d     = 1'b1;
                    state_d     = StFound;
                end else if (next_step > ext_t'(key_hi_q)) begin
                    exhausted_d = 1'b1;
                    state_d     = StExhausted;
                end else begin
                    next_key_d = next_step[SEARCH_BITS-1:0];
                    load_round = 1'b1;
                    state_d    = StDispatch;
                end
            end
            default: state_d = StIdle;
        endcase

        // Build the next round's active mask and keys; compare in SEARCH_BITS+1 bits so the
        // top of the range never wraps back to key 0.
        if (load_round) begin
            core_key_d = '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                cand            = ext_t'(next_key_d) + ext_t'(i);
                core_start_d[i] = (cand <= ext_t'(key_hi_d));
                if (core_start_d[i]) begin
                    core_key_d[i*KEY_WIDTH +: KEY_WIDTH] = KEY_WIDTH'(cand[SEARCH_BITS-1:0]);
                end
            end
            active_d = core_start_d;
        end

        if (bus.abort && (state_q inside {StDispatch, StWait, StEval})) begin
            state_d      = StIdle;
            core_start_d = '0;
            found_d      = 1'b0;
            exhausted_d  = 1'b0;
        end

        busy_d = (state_d inside {StDispatch, StWait, StEval});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            next_key_q   <= '0;
            key_hi_q     <= '0;
            active_q     <= '0;
            done_q       <= '0;
            succ_q       <= '0;
            core_start_q <= '0;
            core_key_q   <= '0;
            busy_q       <= 1'b0;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            found_key_q  <= '0;
            keys_tried_q <= '0;
        end else begin
            state_q      <= state_d;
            next_key_q   <= next_key_d;
            key_hi_q     <= key_hi_d;
            active_q     <= active_d;
            done_q       <= done_d;
            succ_q       <= succ_d;
            core_start_q <= core_start_d;
            core_key_q   <= core_key_d;
            busy_q       <= busy_d;
            found_q      <= found_d;
            exhausted_q  <= exhausted_d;
            found_key_q  <= found_key_d;
            keys_tried_q <= keys_tried_d;
        end
    end

    assign bus.core_start = core_start_q;
    assign bus.core_key   = core_key_q;
    assign bus.busy       = busy_q;
    assign bus.found      = found_q;
    assign bus.exhausted  = exhausted_q;
    assign bus.found_key  = found_key_q;
    assign bus.keys_tried = keys_tried_q;
endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: table of searches run against a latency-staggered core
// model, plus hand-written reset-in-WAIT, abort and empty-range sequences.
module tb_rc4_key_search_ctrl;
    localparam int KW = 24;
    localparam int SB = 22;
    localparam int NC = 4;
    localparam logic [KW-1:0] NONE = 24'hFFFFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rc4_key_search_ctrl_if #(.KEY_WIDTH(KW), .SEARCH_BITS(SB), .NUM_CORES(NC)) bus();

    rc4_key_search_ctrl #(.KEY_WIDTH(KW), .SEARCH_BITS(SB), .NUM_CORES(NC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [SB-1:0]    lo;
        logic [SB-1:0]    hi;
        logic [KW-1:0]    win_a;
        logic [KW-1:0]    win_b;
        bit               same_lat;
        bit               exp_found;
        bit               exp_exh;
        logic [KW-1:0]    exp_key;
        logic [SB:0]      exp_kt;
        int               exp_rounds;
        logic [NC-1:0]    exp_start;
        logic [NC*KW-1:0] exp_keys;
    } vec_t;

    vec_t vecs[7];
    int n_checks = 0;
    int n_errors = 0;
    int rounds;
    logic [NC-1:0]    last_start;
    logic [NC*KW-1:0] last_keys;

    function automatic vec_t mk(input logic [SB-1:0] lo, input logic [SB-1:0] hi,
                                input logic [KW-1:0] wa, input logic [KW-1:0] wb,
                                input bit same, input bit ef, input bit ee,
                                input logic [KW-1:0] ek, input logic [SB:0] ekt,
                                input int er, input logic [NC-1:0] es,
                                input logic [NC*KW-1:0] eks);
        vec_t v;
        v.lo = lo; v.hi = hi; v.win_a = wa; v.win_b = wb; v.same_lat = same;
        v.exp_found = ef; v.exp_exh = ee; v.exp_key = ek; v.exp_kt = ekt;
        v.exp_rounds = er; v.exp_start = es; v.exp_keys = eks;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core model: core i answers NC-i cycles after its start pulse (or 2 cycles when
    // same_lat), so dones of one round normally arrive in different cycles.
    task automatic run_search(input vec_t v, output bit timed_out);
        int            cnt[NC];
        logic [KW-1:0] pend[NC];
        logic [NC-1:0] dv, sv;
        bit            stop;
        rounds     = 0;
        last_start = '0;
        last_keys  = '0;
        for (int i = 0; i < NC; i++) begin
            cnt[i]  = 0;
            pend[i] = '0;
        end
        @(negedge clk);
        bus.key_lo = v.lo;
        bus.key_hi = v.hi;
        bus.start  = 1'b1;
        stop       = 1'b0;
        timed_out  = 1'b1;
        for (int c = 0; c < 400 && !stop; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            dv = '0;
            sv = '0;
            if (bus.core_start != '0) begin
                rounds++;
                last_start = bus.core_start;
                last_keys  = bus.core_key;
                for (int i = 0; i < NC; i++) begin
                    if (bus.core_start[i]) begin
                        cnt[i]  = v.same_lat ? 2 : NC - i;
                        pend[i] = bus.core_key[i*KW +: KW];
                    end
                end
            end else begin
                for (int i = 0; i < NC; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            dv[i] = 1'b1;
                            sv[i] = (pend[i] == v.win_a) || (pend[i] == v.win_b);
                        end
                    end
                end
            end
            bus.core_done    = dv;
            bus.core_success = sv;
            if ((bus.found || bus.exhausted) && !bus.busy) begin
                stop      = 1'b1;
                timed_out = 1'b0;
            end
        end
        bus.core_done    = '0;
        bus.core_success = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " core_start"}, bus.core_start, '0);
        check({tag, " core_key"}, bus.core_key, '0);
        check({tag, " busy"}, bus.busy, 1'b0);
        check({tag, " found"}, bus.found, 1'b0);
        check({tag, " exhausted"}, bus.exhausted, 1'b0);
        check({tag, " found_key"}, bus.found_key, '0);
        check({tag, " keys_tried"}, bus.keys_tried, '0);
    endtask

    initial begin
        bit to;
        //            lo        hi          win_a      win_b  same found exh key        kt  rnd start
        vecs[0] = mk(22'h0, 22'hF, 24'h0B, NONE, 0, 1, 0, 24'h0B, 23'd12, 3, 4'b1111,
                     {24'd11, 24'd10, 24'd9, 24'd8});
        vecs[1] = mk(22'h4, 22'hF, 24'h05, 24'h06, 0, 1, 0, 24'h05, 23'd4, 1, 4'b1111,
                     {24'd7, 24'd6, 24'd5, 24'd4});
        vecs[2] = mk(22'h0, 22'h9, NONE, NONE, 0, 0, 1, 24'h0, 23'd10, 3, 4'b0011,
                     {24'd0, 24'd0, 24'd9, 24'd8});
        vecs[3] = mk(22'h3FFFFE, 22'h3FFFFF, NONE, NONE, 0, 0, 1, 24'h0, 23'd2, 1, 4'b0011,
                     {24'd0, 24'd0, 24'h3FFFFF, 24'h3FFFFE});
        vecs[4] = mk(22'h10, 22'hF, NONE, NONE, 0, 0, 1, 24'h0, 23'd0, 0, 4'b0000, '0);
        vecs[5] = mk(22'h0, 22'h7, 24'h06, NONE, 1, 1, 0, 24'h06, 23'd8, 2, 4'b1111,
                     {24'd7, 24'd6, 24'd5, 24'd4});
        vecs[6] = mk(22'h0, 22'h7, NONE, NONE, 0, 0, 1, 24'h0, 23'd8, 2, 4'b1111,
                     {24'd7, 24'd6, 24'd5, 24'd4});

        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.key_lo       = '0;
        bus.key_hi       = '0;
        bus.core_done    = '0;
        bus.core_success = '0;
        reset            = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int r = 0; r < 7; r++) begin
            run_search(vecs[r], to);
            check($sformatf("v%0d timeout", r), to, 1'b0);
            check($sformatf("v%0d found", r), bus.found, vecs[r].exp_found);
            check($sformatf("v%0d exhausted", r), bus.exhausted, vecs[r].exp_exh);
            if (vecs[r].exp_found) begin
                check($sformatf("v%0d found_key", r), bus.found_key, vecs[r].exp_key);
            end
            check($sformatf("v%0d keys_tried", r), bus.keys_tried, vecs[r].exp_kt);
            check($sformatf("v%0d rounds", r), rounds, vecs[r].exp_rounds);
            check($sformatf("v%0d last core_start", r), last_start, vecs[r].exp_start);
            check($sformatf("v%0d last core_key", r), last_keys, vecs[r].exp_keys);
            check($sformatf("v%0d core_start idle", r), bus.core_start, '0);
        end

        // Empty range: exhausted on the very next cycle, no dispatch.
        @(negedge clk);
        bus.key_lo = 22'h20;
        bus.key_hi = 22'h1F;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("empty exhausted", bus.exhausted, 1'b1);
        check("empty busy", bus.busy, 1'b0);
        check("empty core_start", bus.core_start, '0);
        check("empty keys_tried", bus.keys_tried, '0);

        // Reset while waiting, then late all-success dones must be ignored.
        @(negedge clk);
        bus.key_lo = 22'h0;
        bus.key_hi = 22'hF;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("rst dispatch core_start", bus.core_start, 4'b1111);
        @(negedge clk);
        check("rst wait busy", bus.busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset            = 1'b0;
        bus.core_done    = 4'b1111;
        bus.core_success = 4'b1111;
        @(negedge clk);
        bus.core_done    = '0;
        bus.core_success = '0;
        check_reset_outputs("post-reset");
        repeat (3) @(negedge clk);
        check_reset_outputs("post-reset hold");

        // Abort while waiting: keys_tried kept, late dones ignored.
        bus.key_lo = 22'h0;
        bus.key_hi = 22'hF;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.core_done    = 4'b1000;
        bus.core_success = 4'b0000;
        @(negedge clk);
        bus.core_done = '0;
        check("abort pre keys_tried", bus.keys_tried, 23'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort        = 1'b0;
        bus.core_done    = 4'b1111;
        bus.core_success = 4'b1111;
        check("abort busy", bus.busy, 1'b0);
        check("abort core_start", bus.core_start, '0);
        @(negedge clk);
        bus.core_done    = '0;
        bus.core_success = '0;
        repeat (2) @(negedge clk);
        check("abort found", bus.found, 1'b0);
        check("abort exhausted", bus.exhausted, 1'b0);
        check("abort busy hold", bus.busy, 1'b0);
        check("abort keys_tried", bus.keys_tried, 23'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
